mix_columns_seq: RTL

Column-serial forward AES MixColumns unit with a valid/ready handshake on both sides. It accepts one 128-bit state and processes one 32-bit column per clock. It presents the result until the downstream stage accepts it. It sits in the encryption round datapath after ShiftRows and before AddRoundKey, and is the forward counterpart of the combinational inverse MixColumns used on the decryption path.

---
 rtl/mix_columns_seq.sv | 83 ++++++++
 1 files changed

// File: rtl/mix_columns_seq.sv
// Column-serial AES MixColumns: one 32-bit column per clock, 4 cycles from accept to outValid.
// Result is held in DONE until outReady; inReady is high only in IDLE.
module mix_columns_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic [0:127] inState,
  input  logic         inValid,
  output logic         inReady,
  output logic [0:127] outState,
  output logic         outValid,
  input  logic         outReady
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t       state;
  state_t       next_state;
  logic [0:127] w;
  logic [1:0]   col;
  logic [31:0]  col_in;
  logic [31:0]  col_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul3(input logic [7:0] a);
    return xtime(a) ^ a;
  endfunction

  // Single shared column datapath; row 0 of the column is the MSB byte of col_in.
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    col_in  = w[{col, 5'd0} +: 32];
    a0      = col_in[31:24];
    a1      = col_in[23:16];
    a2      = col_in[15:8];
    a3      = col_in[7:0];
    col_out = {xtime(a0) ^ mul3(a1) ^ a2 ^ a3,
               a0 ^ xtime(a1) ^ mul3(a2) ^ a3,
               a0 ^ a1 ^ xtime(a2) ^ mul3(a3),
               mul3(a0) ^ a1 ^ a2 ^ xtime(a3)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      w     <= '0;
      col   <= 2'd0;
    end else begin
      state <= next_state;
      case (state)
        IDLE: if (inValid) begin
          w   <= inState;
          col <= 2'd0;
        end
        BUSY: begin
          w[{col, 5'd0} +: 32] <= col_out;
          col                  <= col + 2'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (inValid) next_state = BUSY;
      BUSY:    if (col == 2'd3) next_state = DONE;
      DONE:    if (outReady) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // inReady is gated by rst so a held reset never advertises acceptance.
  always_comb begin
    inReady  = (state == IDLE) && !rst;
    outValid = (state == DONE);
    outState = w;
  end

endmodule
